// File: rtl/if_fetch_pkg.sv
// Shared state encoding and sizing constants for the byte-serial fetch stage.
// The optional instruction cache is enabled by defining ICACHE_EN.
package if_fetch_pkg;

    localparam int MEM_BYTE_LEN         = 8;
    localparam int ICACHE_LINES_DEFAULT = 128;

    typedef enum logic [2:0] {
        IF_RD0,
        IF_RD1,
        IF_RD2,
        IF_RD3,
        IF_DONE
    } if_state_e;

    // Byte offset requested in a read state; also the index of the byte that lands one cycle later.
    function automatic logic [1:0] rd_index(input if_state_e s);
        case (s)
            IF_RD1:  return 2'd1;
            IF_RD2:  return 2'd2;
            IF_RD3:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic if_state_e rd_next(input if_state_e s);
        case (s)
            IF_RD0:  return IF_RD1;
            IF_RD1:  return IF_RD2;
            IF_RD2:  return IF_RD3;
            default: return IF_DONE;
        endcase
    endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup, single write port.
// Only instantiated by if_fetch when ICACHE_EN is defined.
module if_icache
    import if_fetch_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int INST_LEN = 32,
    parameter int LINES    = ICACHE_LINES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] addr,
    output logic                hit,
    output logic [INST_LEN-1:0] data,
    input  logic                we,
    input  logic [INST_LEN-1:0] wdata
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_LEN - IDX_W;

    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tags  [LINES];
    logic [INST_LEN-1:0] lines [LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    // The byte offset stays in the tag so an unaligned pc never aliases an aligned line.
    assign idx  = addr[IDX_W+1:2];
    assign tag  = {addr[ADDR_LEN-1:IDX_W+2], addr[1:0]};
    assign hit  = valid[idx] && (tags[idx] == tag);
    assign data = lines[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone qualify them, so the RAMs map cleanly.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[idx]  <= tag;
            lines[idx] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a little-endian word from four byte reads and hands it to if_id.
// Define ICACHE_EN to add a direct-mapped cache that can deliver in the first read cycle.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int INST_LEN = 32
`ifdef ICACHE_EN
    ,
    parameter int ICACHE_LINES = ICACHE_LINES_DEFAULT
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_LEN-1:0]     pc_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    mem_busy_i,
    input  logic [MEM_BYTE_LEN-1:0] mem_din_i,
    output logic                    mem_req_o,
    output logic [ADDR_LEN-1:0]     mem_addr_o,
    output logic [INST_LEN-1:0]     inst_o,
    output logic [ADDR_LEN-1:0]     inst_pc_o,
    output logic                    inst_valid_o,
    output logic                    stallreq_o
);

    if_state_e           state;
    logic                pend;
    logic                hold;
    logic [INST_LEN-1:0] inst_buf;

    logic                hit;
    logic [INST_LEN-1:0] hit_data;
    logic                hit_rd0;
    logic                deliver;
    logic                req;
    logic                valid;
    logic [INST_LEN-1:0] assembled;

`ifdef ICACHE_EN
    if_icache #(
        .ADDR_LEN (ADDR_LEN),
        .INST_LEN (INST_LEN),
        .LINES    (ICACHE_LINES)
    ) u_icache (
        .clk   (clk),
        .rst   (rst),
        .addr  (pc_i),
        .hit   (hit),
        .data  (hit_data),
        .we    ((state == IF_DONE) && !flush_i),
        .wdata (assembled)
    );
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // NOTE: every signal below is assigned on all paths, so no latch can be inferred.
    always_comb begin
        hit_rd0 = (state == IF_RD0) && hit;
        deliver = (state == IF_DONE) || hit_rd0;
        if (hit_rd0) begin
            assembled = hit_data;
        end else if (hold) begin
            assembled = inst_buf;
        end else begin
            assembled = {mem_din_i, inst_buf[INST_LEN-MEM_BYTE_LEN-1:0]};
        end
        req   = !rst && !flush_i && !deliver && !mem_busy_i;
        valid = !rst && !flush_i && deliver;
    end

    assign mem_req_o    = req;
    assign mem_addr_o   = req ? pc_i + ADDR_LEN'(rd_index(state)) : '0;
    assign inst_valid_o = valid;
    assign inst_o       = valid ? assembled : '0;
    assign inst_pc_o    = valid ? pc_i : '0;
    assign stallreq_o   = !rst && !flush_i && !deliver;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IF_RD0;
            pend     <= 1'b0;
            hold     <= 1'b0;
            inst_buf <= '0;
        end else if (flush_i) begin
            state <= IF_RD0;
            pend  <= 1'b0;
            hold  <= 1'b0;
        end else begin
            // The byte requested last cycle lands now, even if this cycle is busy.
            if (pend) begin
                case (state)
                    IF_RD1:  inst_buf[7:0]   <= mem_din_i;
                    IF_RD2:  inst_buf[15:8]  <= mem_din_i;
                    IF_RD3:  inst_buf[23:16] <= mem_din_i;
                    default: ;
                endcase
            end
            if (deliver) begin
                pend <= 1'b0;
                if (stall_i) begin
                    inst_buf <= assembled;
                    hold     <= 1'b1;
                    state    <= IF_DONE;
                end else begin
                    hold  <= 1'b0;
                    state <= IF_RD0;
                end
            end else begin
                pend <= !mem_busy_i;
                if (!mem_busy_i) begin
                    state <= rd_next(state);
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic against a
// request-count model of the fetch protocol. Cache checks are active when ICACHE_EN is defined.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        mem_busy_i;
    logic [7:0]  mem_din_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stallreq_o;

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .mem_busy_i   (mem_busy_i),
        .mem_din_i    (mem_din_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory image: a few pinned bytes, everything else a fixed hash of the address.
    logic [7:0] mem_ovr [int unsigned];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    // Model: number of byte requests issued for the current pc (4 = word complete).
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    int          nreq;
    bit          pend_valid;
    logic [31:0] pend_addr;

    bit          cvalid [128];
    logic [31:0] cpc    [128];

    bit          obs_valid;
    bit          obs_req;
    logic [31:0] obs_inst;
    logic [31:0] obs_pc;
    logic [31:0] obs_addr;

    task automatic cycle(input bit r, input bit s, input bit f, input bit b);
        bit exp_hit;
        bit exp_valid;
        bit exp_req;
        rst        = r;
        stall_i    = s;
        flush_i    = f;
        mem_busy_i = b;
        pc_i       = cur_pc;
        mem_din_i  = pend_valid ? mem_byte(pend_addr) : 8'($urandom);
        @(negedge clk);
        obs_valid = inst_valid_o;
        obs_req   = mem_req_o;
        obs_inst  = inst_o;
        obs_pc    = inst_pc_o;
        obs_addr  = mem_addr_o;

        exp_hit = 1'b0;
`ifdef ICACHE_EN
        exp_hit = !r && !f && (nreq == 0) && cvalid[cur_pc[8:2]] && (cpc[cur_pc[8:2]] == cur_pc);
`endif
        exp_valid = !r && !f && ((nreq == 4) || exp_hit);
        exp_req   = !r && !f && !exp_valid && !b;

        check("valid", 32'(inst_valid_o), 32'(exp_valid));
        check("req", 32'(mem_req_o), 32'(exp_req));
        check("stallreq", 32'(stallreq_o), 32'(!r && !f && !exp_valid));
        if (exp_req) check("addr", mem_addr_o, cur_pc + 32'(nreq));
        if (exp_valid) begin
            check("inst", inst_o, word_at(cur_pc));
            check("inst_pc", inst_pc_o, cur_pc);
        end
        if (r) check("rst_outs", 32'(|{mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stallreq_o}), 32'd0);

        pend_valid = mem_req_o;
        pend_addr  = mem_addr_o;
        if (r) begin
            nreq = 0;
            for (int i = 0; i < 128; i++) cvalid[i] = 1'b0;
        end else if (f) begin
            nreq   = 0;
            cur_pc = next_pc;
        end else if (exp_valid) begin
            if (nreq == 4) begin
                cvalid[cur_pc[8:2]] = 1'b1;
                cpc[cur_pc[8:2]]    = cur_pc;
            end
            if (s) begin
                nreq = 4;
            end else begin
                nreq   = 0;
                cur_pc = next_pc;
            end
        end else if (exp_req) begin
            nreq++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        cur_pc  = pc;
        next_pc = pc;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Runs idle cycles until a delivery; returns its cycle count (0 if the bound expires).
    task automatic run_to_valid(input int bound, output int lat, output logic [31:0] inst);
        lat  = 0;
        inst = '0;
        for (int i = 1; i <= bound; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (obs_valid) begin
                lat  = i;
                inst = obs_inst;
                break;
            end
        end
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [6];
        logic [31:0] p;
        pool = '{32'h0, 32'h40, 32'h200, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h1000_0000};
        p = ($urandom_range(1) == 0) ? pool[$urandom_range(5)] : $urandom;
`ifdef ICACHE_EN
        p[1:0] = 2'b00;
`endif
        return p;
    endfunction

    int          lat;
    logic [31:0] got;
    logic [31:0] held_inst;
    logic [31:0] held_pc;

    initial begin
        rst        = 1'b1;
        pc_i       = '0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        mem_busy_i = 1'b0;
        mem_din_i  = '0;
        cur_pc     = '0;
        next_pc    = '0;
        nreq       = 0;
        pend_valid = 1'b0;
        pend_addr  = '0;
        for (int i = 0; i < 128; i++) begin
            cvalid[i] = 1'b0;
            cpc[i]    = '0;
        end
        mem_ovr[0] = 8'h13;
        mem_ovr[1] = 8'h05;
        mem_ovr[2] = 8'h10;
        mem_ovr[3] = 8'h00;
        @(posedge clk);
        #1;

        // Basic fetch of pc 0: valid in cycle 5.
        do_reset(32'h0);
        next_pc = 32'h1000;
        run_to_valid(20, lat, got);
        check("lat_basic", 32'(lat), 32'd5);
        check("inst_basic", got, 32'h0010_0513);

        // Busy for three cycles in RD2 delays delivery by three cycles.
        do_reset(32'h0);
        next_pc = 32'h1000;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check("busy_no_req", 32'(obs_req), 32'd0);
        end
        run_to_valid(20, lat, got);
        check("lat_busy", 32'(lat + 5), 32'd8);
        check("inst_busy", got, 32'h0010_0513);

        // Flush in RD2 restarts at the jump target.
        do_reset(32'h0);
        next_pc = 32'h100;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        next_pc = 32'h2000;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_req", 32'(obs_req), 32'd1);
        check("flush_addr", obs_addr, 32'h100);
        run_to_valid(20, lat, got);
        check("flush_inst", got, word_at(32'h100));

        // Two stalled DONE cycles hold the word; the next fetch starts once stall drops.
        do_reset(32'h40);
        next_pc = 32'h80;
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        held_inst = obs_inst;
        held_pc   = obs_pc;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("stall_inst", obs_inst, held_inst);
        check("stall_pc", obs_pc, held_pc);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_release_valid", 32'(obs_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("after_stall_addr", obs_addr, 32'h80);

        // Reset asserted in RD3, then the fetch restarts at RD0 with the current pc.
        do_reset(32'h200);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_restart_addr", obs_addr, 32'h200);

        // Address wrap past 0xFFFFFFFF.
        do_reset(32'hFFFF_FFFE);
        next_pc = 32'h0;
        run_to_valid(20, lat, got);
        check("wrap_inst", got, word_at(32'hFFFF_FFFE));

`ifdef ICACHE_EN
        // Refetch of pc 0 hits in RD0 without a memory request.
        do_reset(32'h0);
        next_pc = 32'h0;
        run_to_valid(20, lat, got);
        next_pc = 32'h40;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("hit_valid", 32'(obs_valid), 32'd1);
        check("hit_req", 32'(obs_req), 32'd0);
        check("hit_inst", obs_inst, got);
`endif

        // Randomized traffic against the model.
        do_reset(pick_pc());
        for (int i = 0; i < 3000; i++) begin
            next_pc = pick_pc();
            cycle($urandom_range(63) == 0, $urandom_range(2) == 0,
                  $urandom_range(19) == 0, $urandom_range(2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
